// File: rtl/hazard_bypass_unit_if.sv
// hazard_bypass_unit_if: ID/EX/MEM/load-response hazard bus between the pipeline and the bypass unit
interface hazard_bypass_unit_if #(
  parameter int REGFILE_ADDR_WIDTH = 5,
  parameter int NUM_SRC = 2,
  parameter int STALL_CNT_WIDTH = 16
);
  logic id_valid;
  logic [NUM_SRC*REGFILE_ADDR_WIDTH-1:0] id_rs_addr;
  logic [NUM_SRC-1:0] id_src_is_imm;
  logic id_is_load;
  logic [REGFILE_ADDR_WIDTH-1:0] id_rd_addr;
  logic ex_valid;
  logic ex_wr_en;
  logic ex_is_load;
  logic [REGFILE_ADDR_WIDTH-1:0] ex_rd_addr;
  logic mem_valid;
  logic mem_wr_en;
  logic mem_is_load;
  logic [REGFILE_ADDR_WIDTH-1:0] mem_rd_addr;
  logic load_rsp_valid;
  logic [REGFILE_ADDR_WIDTH-1:0] load_rsp_rd_addr;
  logic flush;
  logic [2*NUM_SRC-1:0] forward_sel;
  logic stall;
  logic [3:0] outstanding;
  logic [STALL_CNT_WIDTH-1:0] stall_count;
  logic sb_error;
  modport master (
    output id_valid, id_rs_addr, id_src_is_imm, id_is_load, id_rd_addr,
           ex_valid, ex_wr_en, ex_is_load, ex_rd_addr,
           mem_valid, mem_wr_en, mem_is_load, mem_rd_addr,
           load_rsp_valid, load_rsp_rd_addr, flush,
    input  forward_sel, stall, outstanding, stall_count, sb_error
  );
  modport slave (
    input  id_valid, id_rs_addr, id_src_is_imm, id_is_load, id_rd_addr,
           ex_valid, ex_wr_en, ex_is_load, ex_rd_addr,
           mem_valid, mem_wr_en, mem_is_load, mem_rd_addr,
           load_rsp_valid, load_rsp_rd_addr, flush,
    output forward_sel, stall, outstanding, stall_count, sb_error
  );
endinterface

// File: rtl/hazard_bypass_unit.sv
// hazard_bypass_unit: operand bypass select, load scoreboard and ID stall generation
module hazard_bypass_unit #(
  parameter int REGFILE_ADDR_WIDTH = 5,
  parameter int NUM_SRC = 2,
  parameter int MAX_OUTSTANDING = 2,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic Clk,
  input  logic Reset_n,
  hazard_bypass_unit_if.slave bus
);
  localparam int W = REGFILE_ADDR_WIDTH;
  localparam int NREG = 1 << W;
  logic [NREG-1:0] pending_q, pending_d;
  logic [3:0] outstanding_q, outstanding_d;
  logic [STALL_CNT_WIDTH-1:0] stall_count_q, stall_count_d;
  logic sb_error_q, sb_error_d;
  logic [2*NUM_SRC-1:0] fwd;
  logic [NUM_SRC-1:0] src_stall;
  logic issue, rsp_hit, rsp_bad, cap_stall, waw_stall, stall;
  genvar s;
  for (s = 0; s < NUM_SRC; s++) begin : g_src
    logic [W-1:0] a;
    logic need, ex_hit, mem_hit, pend, rsp_m;
    assign a = bus.id_rs_addr[s*W +: W];
    assign need = bus.id_valid & ~bus.id_src_is_imm[s] & |a;
    assign ex_hit = bus.ex_valid & bus.ex_wr_en & (bus.ex_rd_addr == a);
    assign mem_hit = bus.mem_valid & bus.mem_wr_en & ~bus.mem_is_load & (bus.mem_rd_addr == a);
    assign pend = pending_q[a];
    assign rsp_m = bus.load_rsp_valid & (bus.load_rsp_rd_addr == a);
    // youngest producer wins; a MEM load falls through to the scoreboard check
    assign fwd[2*s +: 2] = !need ? 2'b00 :
                           ex_hit ? (bus.ex_is_load ? 2'b00 : 2'b10) :
                           mem_hit ? 2'b01 :
                           (pend & rsp_m) ? 2'b11 : 2'b00;
    assign src_stall[s] = need & (ex_hit ? bus.ex_is_load : ~mem_hit & pend & ~rsp_m);
  end
  assign issue = bus.ex_valid & bus.ex_is_load & bus.ex_wr_en & |bus.ex_rd_addr & ~bus.flush;
  assign rsp_hit = bus.load_rsp_valid & pending_q[bus.load_rsp_rd_addr];
  assign rsp_bad = bus.load_rsp_valid & ~pending_q[bus.load_rsp_rd_addr];
  assign cap_stall = bus.id_valid & bus.id_is_load & (outstanding_q == 4'(MAX_OUTSTANDING)) & ~rsp_hit;
  assign waw_stall = bus.id_valid & bus.id_is_load & pending_q[bus.id_rd_addr];
  assign stall = (|src_stall | cap_stall | waw_stall) & ~bus.flush;
  always_comb begin
    pending_d = pending_q;
    if (rsp_hit) pending_d[bus.load_rsp_rd_addr] = 1'b0;
    if (issue) pending_d[bus.ex_rd_addr] = 1'b1;
  end
  assign outstanding_d = outstanding_q + {3'b000, issue} - {3'b000, rsp_hit};
  assign stall_count_d = (stall & ~&stall_count_q) ? stall_count_q + 1'b1 : stall_count_q;
  assign sb_error_d = sb_error_q | rsp_bad;
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pending_q <= '0;
      outstanding_q <= '0;
      stall_count_q <= '0;
      sb_error_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      outstanding_q <= outstanding_d;
      stall_count_q <= stall_count_d;
      sb_error_q <= sb_error_d;
    end
  end
  assign bus.forward_sel = fwd;
  assign bus.stall = stall;
  assign bus.outstanding = outstanding_q;
  assign bus.stall_count = stall_count_q;
  assign bus.sb_error = sb_error_q;
endmodule

// File: tb/tb_hazard_bypass_unit.sv
// tb_hazard_bypass_unit: vector table, hand sequences and randomized checks against a scoreboard model
module tb_hazard_bypass_unit;
  localparam int CW = 4;
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 Clk = ~Clk;
  hazard_bypass_unit_if #(.REGFILE_ADDR_WIDTH(5), .NUM_SRC(2), .STALL_CNT_WIDTH(CW)) bus ();
  hazard_bypass_unit #(.REGFILE_ADDR_WIDTH(5), .NUM_SRC(2), .MAX_OUTSTANDING(2), .STALL_CNT_WIDTH(CW))
    dut (.Clk(Clk), .Reset_n(Reset_n), .bus(bus));
  typedef struct {
    logic id_v;
    logic [4:0] rs0, rs1;
    logic [1:0] imm;
    logic ex_v, ex_wr, ex_ld;
    logic [4:0] ex_rd;
    logic mem_v, mem_wr, mem_ld;
    logic [4:0] mem_rd;
    logic [3:0] sel;
    logic st;
  } vec_t;
  vec_t tv[$];
  bit [31:0] pend;
  int mout, mcnt;
  bit merr;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic vec(input int idv, input int r0, input int r1, input int imm,
                     input int exv, input int exw, input int exl, input int exr,
                     input int mv, input int mw, input int ml, input int mr,
                     input int sel, input int st);
    vec_t v;
    v.id_v = 1'(idv); v.rs0 = 5'(r0); v.rs1 = 5'(r1); v.imm = 2'(imm);
    v.ex_v = 1'(exv); v.ex_wr = 1'(exw); v.ex_ld = 1'(exl); v.ex_rd = 5'(exr);
    v.mem_v = 1'(mv); v.mem_wr = 1'(mw); v.mem_ld = 1'(ml); v.mem_rd = 5'(mr);
    v.sel = 4'(sel); v.st = 1'(st);
    tv.push_back(v);
  endtask
  task automatic idle();
    bus.id_valid = 0; bus.id_rs_addr = '0; bus.id_src_is_imm = '0; bus.id_is_load = 0; bus.id_rd_addr = '0;
    bus.ex_valid = 0; bus.ex_wr_en = 0; bus.ex_is_load = 0; bus.ex_rd_addr = '0;
    bus.mem_valid = 0; bus.mem_wr_en = 0; bus.mem_is_load = 0; bus.mem_rd_addr = '0;
    bus.load_rsp_valid = 0; bus.load_rsp_rd_addr = '0; bus.flush = 0;
  endtask
  task automatic ex_load(input int rd);
    bus.ex_valid = 1; bus.ex_wr_en = 1; bus.ex_is_load = 1; bus.ex_rd_addr = 5'(rd);
  endtask
  task automatic id_read(input int r0, input int r1);
    bus.id_valid = 1; bus.id_rs_addr = {5'(r1), 5'(r0)};
  endtask
  task automatic id_load(input int rd);
    bus.id_valid = 1; bus.id_is_load = 1; bus.id_rd_addr = 5'(rd);
  endtask
  task automatic rsp(input int rd);
    bus.load_rsp_valid = 1; bus.load_rsp_rd_addr = 5'(rd);
  endtask
  task automatic do_reset();
    @(negedge Clk); idle(); Reset_n = 0;
    @(negedge Clk); Reset_n = 1;
  endtask
  task automatic model_out(output logic [3:0] sel, output logic st);
    logic [4:0] a;
    bit rok;
    sel = '0; st = 0;
    for (int i = 0; i < 2; i++) begin
      a = bus.id_rs_addr[i*5 +: 5];
      if (!bus.id_valid || bus.id_src_is_imm[i] || a == 0) continue;
      if (bus.ex_valid && bus.ex_wr_en && bus.ex_rd_addr == a) begin
        if (bus.ex_is_load) st = 1; else sel[2*i +: 2] = 2'b10;
      end else if (bus.mem_valid && bus.mem_wr_en && !bus.mem_is_load && bus.mem_rd_addr == a)
        sel[2*i +: 2] = 2'b01;
      else if (pend[a]) begin
        if (bus.load_rsp_valid && bus.load_rsp_rd_addr == a) sel[2*i +: 2] = 2'b11; else st = 1;
      end
    end
    rok = bus.load_rsp_valid && pend[bus.load_rsp_rd_addr];
    if (bus.id_valid && bus.id_is_load && ((mout == 2 && !rok) || pend[bus.id_rd_addr])) st = 1;
    if (bus.flush) st = 0;
  endtask
  initial begin
    logic [3:0] esel;
    logic est;
    bit rok, iss;
    idle();
    vec(1, 5, 5, 0, 1, 1, 0, 5, 0, 0, 0, 0, 4'b1010, 0);
    vec(1, 5, 5, 2, 1, 1, 0, 5, 0, 0, 0, 0, 4'b0010, 0);
    vec(1, 7, 0, 0, 1, 1, 0, 7, 1, 1, 0, 7, 4'b0010, 0);
    vec(1, 7, 0, 0, 1, 1, 0, 0, 1, 1, 0, 7, 4'b0001, 0);
    vec(1, 0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 4'b0000, 0);
    vec(1, 0, 3, 0, 1, 1, 1, 3, 0, 0, 0, 0, 4'b0000, 1);
    vec(1, 7, 0, 0, 0, 0, 0, 0, 1, 1, 1, 7, 4'b0000, 0);
    vec(1, 5, 5, 0, 1, 0, 0, 5, 1, 1, 0, 5, 4'b0101, 0);
    vec(1, 5, 0, 0, 0, 1, 0, 5, 0, 0, 0, 0, 4'b0000, 0);
    vec(1, 5, 6, 0, 1, 1, 0, 5, 1, 1, 0, 6, 4'b0110, 0);
    vec(1, 0, 3, 2, 1, 1, 1, 3, 0, 0, 0, 0, 4'b0000, 0);
    vec(0, 5, 5, 0, 1, 1, 0, 5, 1, 1, 0, 5, 4'b0000, 0);
    vec(1, 3, 3, 0, 1, 1, 1, 3, 1, 1, 0, 3, 4'b0000, 1);
    repeat (2) @(negedge Clk);
    #1;
    chk("rst_sel", 32'(bus.forward_sel), 0);
    chk("rst_stall", 32'(bus.stall), 0);
    chk("rst_out", 32'(bus.outstanding), 0);
    chk("rst_cnt", 32'(bus.stall_count), 0);
    chk("rst_err", 32'(bus.sb_error), 0);
    // reset held: scoreboard stays empty so each vector is purely combinational
    foreach (tv[k]) begin
      @(negedge Clk);
      idle();
      bus.id_valid = tv[k].id_v; bus.id_rs_addr = {tv[k].rs1, tv[k].rs0}; bus.id_src_is_imm = tv[k].imm;
      bus.ex_valid = tv[k].ex_v; bus.ex_wr_en = tv[k].ex_wr; bus.ex_is_load = tv[k].ex_ld; bus.ex_rd_addr = tv[k].ex_rd;
      bus.mem_valid = tv[k].mem_v; bus.mem_wr_en = tv[k].mem_wr; bus.mem_is_load = tv[k].mem_ld; bus.mem_rd_addr = tv[k].mem_rd;
      #1;
      chk($sformatf("vec%0d_sel", k), 32'(bus.forward_sel), 32'(tv[k].sel));
      chk($sformatf("vec%0d_stall", k), 32'(bus.stall), 32'(tv[k].st));
    end
    do_reset();
    @(negedge Clk); idle(); ex_load(3); id_read(0, 3); #1;
    chk("lu_stall", 32'(bus.stall), 1);
    @(negedge Clk); idle(); bus.mem_valid = 1; bus.mem_wr_en = 1; bus.mem_is_load = 1; bus.mem_rd_addr = 3;
    rsp(3); id_read(0, 3); #1;
    chk("lu_out", 32'(bus.outstanding), 1);
    chk("lu_sel", 32'(bus.forward_sel), 32'(4'b1100));
    chk("lu_stall2", 32'(bus.stall), 0);
    @(negedge Clk); idle(); id_read(0, 3); #1;
    chk("lu_clear_stall", 32'(bus.stall), 0);
    chk("lu_clear_out", 32'(bus.outstanding), 0);
    chk("lu_cnt", 32'(bus.stall_count), 1);
    @(negedge Clk); idle(); ex_load(9);
    for (int c = 0; c < 4; c++) begin
      @(negedge Clk); idle(); id_read(9, 0); #1;
      chk($sformatf("vl_stall%0d", c), 32'(bus.stall), 1);
    end
    @(negedge Clk); idle(); id_read(9, 0); rsp(9); #1;
    chk("vl_sel", 32'(bus.forward_sel), 32'(4'b0011));
    chk("vl_stall", 32'(bus.stall), 0);
    @(negedge Clk); idle(); ex_load(1); #1;
    chk("vl_cnt", 32'(bus.stall_count), 5);
    @(negedge Clk); idle(); ex_load(2);
    @(negedge Clk); idle(); id_load(4); #1;
    chk("cap_out", 32'(bus.outstanding), 2);
    chk("cap_stall", 32'(bus.stall), 1);
    @(negedge Clk); idle(); id_load(4); rsp(1); ex_load(6); #1;
    chk("cap_rsp_stall", 32'(bus.stall), 0);
    @(negedge Clk); idle(); id_load(2); rsp(6); #1;
    chk("cap_out_kept", 32'(bus.outstanding), 2);
    chk("waw_stall", 32'(bus.stall), 1);
    @(negedge Clk); idle(); ex_load(8); bus.flush = 1; id_read(2, 0); #1;
    chk("fl_stall", 32'(bus.stall), 0);
    chk("fl_out0", 32'(bus.outstanding), 1);
    @(negedge Clk); idle(); id_read(8, 0); #1;
    chk("fl_out1", 32'(bus.outstanding), 1);
    chk("fl_nopend", 32'(bus.stall), 0);
    @(negedge Clk); idle(); rsp(12); #1;
    chk("err_pre", 32'(bus.sb_error), 0);
    @(negedge Clk); idle(); #1;
    chk("err_set", 32'(bus.sb_error), 1);
    repeat (3) @(negedge Clk);
    #1;
    chk("err_sticky", 32'(bus.sb_error), 1);
    @(negedge Clk); idle(); ex_load(10);
    @(negedge Clk); idle(); #1;
    chk("mid_out", 32'(bus.outstanding), 2);
    #1 Reset_n = 0;
    #1;
    chk("mid_rst_out", 32'(bus.outstanding), 0);
    chk("mid_rst_err", 32'(bus.sb_error), 0);
    @(negedge Clk); Reset_n = 1; idle(); rsp(2);
    @(negedge Clk); idle(); #1;
    chk("post_rst_err", 32'(bus.sb_error), 1);
    do_reset();
    pend = '0; mout = 0; mcnt = 0; merr = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge Clk);
      bus.id_valid = ($urandom % 4) != 0;
      bus.id_rs_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      bus.id_src_is_imm = 2'($urandom);
      bus.id_is_load = 1'($urandom);
      bus.id_rd_addr = 5'($urandom_range(0, 7));
      bus.ex_valid = 1'($urandom);
      bus.ex_wr_en = 1'($urandom);
      bus.ex_is_load = (mout < 2) ? 1'($urandom) : 1'b0;
      bus.ex_rd_addr = 5'($urandom_range(0, 7));
      bus.mem_valid = 1'($urandom);
      bus.mem_wr_en = 1'($urandom);
      bus.mem_is_load = 1'($urandom);
      bus.mem_rd_addr = 5'($urandom_range(0, 7));
      bus.load_rsp_rd_addr = 5'($urandom_range(0, 7));
      bus.load_rsp_valid = pend[bus.load_rsp_rd_addr] ? 1'($urandom) : (($urandom % 16) == 0);
      bus.flush = ($urandom % 8) == 0;
      #1;
      model_out(esel, est);
      chk("rnd_sel", 32'(bus.forward_sel), 32'(esel));
      chk("rnd_stall", 32'(bus.stall), 32'(est));
      chk("rnd_out", 32'(bus.outstanding), 32'(mout));
      chk("rnd_cnt", 32'(bus.stall_count), 32'(mcnt));
      chk("rnd_err", 32'(bus.sb_error), 32'(merr));
      rok = bus.load_rsp_valid && pend[bus.load_rsp_rd_addr];
      if (bus.load_rsp_valid && !pend[bus.load_rsp_rd_addr]) merr = 1;
      iss = bus.ex_valid && bus.ex_is_load && bus.ex_wr_en && bus.ex_rd_addr != 0 && !bus.flush;
      if (rok) pend[bus.load_rsp_rd_addr] = 0;
      if (iss) pend[bus.ex_rd_addr] = 1;
      mout = mout + int'(iss) - int'(rok);
      if (est && mcnt < (1 << CW) - 1) mcnt++;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
